voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphony controller in front of the oscillator bank.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of VOICES oscillator slots.
- Drives each slot's enable, freq and cmds inputs.
- Allocation priority: retrigger same key, then lowest free slot, then steal the oldest sounding voice. Released voices are held enabled for a fixed tail before they are freed.

Parameters:
VOICES, 8, number of oscillator slots managed (>=2)
KEY_W, 7, width of note key identifier
AGE_W, 8, width of per-voice saturating age counter
RELEASE_TICKS, 4800, cycles a released voice stays enabled before becoming free (0 = free immediately)

Ports:
clk  in  1  system/sample clock
rst_n  in  1  asynchronous active-low reset
ev_valid  in  1  event present
ev_ready  out  1  allocator can accept event
ev_note_on  in  1  1 = note-on, 0 = note-off
ev_key  in  KEY_W  note identifier
ev_freq  in  32  fixed-point frequency (oscillator freq format); ignored for note-off
voice_enable  out  VOICES  per-slot oscillator enable
voice_freq  out  32*VOICES  per-slot freq; slot i at bits [32i+31:32i]
voice_cmds  out  8*VOICES  per-slot cmds; slot i at [8i+7:8i]
stolen  out  1  one-cycle pulse when a note-on stole a sounding voice

Behaviour:
- Reset values: ev_ready=1, all voice_enable/voice_freq/voice_cmds=0, stolen=0, all slots FREE, ages 0, FSM IDLE.
- Reset is asynchronous: an event in flight mid-scan is dropped.
- Per-slot state: FREE, HELD, RELEASING, plus key, age and rel_cnt.
- voice_enable[i] = 1 iff the slot is HELD or RELEASING.
- FSM IDLE:
  - ev_ready=1.
  - On ev_valid&ev_ready (cycle T), latch note_on/key/freq, go to SCAN, ev_ready=0.
- FSM SCAN:
  - Examines slot i=0..VOICES-1, one slot per cycle (cycles T+1..T+VOICES).
  - Note-on records three candidates:
    - first non-FREE slot with matching key (retrigger);
    - first FREE slot;
    - oldest non-FREE slot: largest age, lowest index on ties.
  - Note-off records the first HELD slot with matching key.
- FSM COMMIT (cycle T+VOICES+1), then return to IDLE:
  - Note-on target is retrigger if found, else first FREE, else oldest.
  - Write target: key, freq, state HELD, age 0.
  - Every other non-FREE slot's age increments, saturating at 2^AGE_W-1.
  - stolen=1 for one cycle only when the oldest-slot path is taken.
  - Note-off with a match: state RELEASING, rel_cnt=RELEASE_TICKS. With no match, nothing changes.
- Outputs update at T+VOICES+2, and ev_ready=1 again that same cycle. Maximum throughput is one event per VOICES+2 cycles.
- Envelope reset:
  - On a note-on commit, voice_cmds[target][ENVELOPE_RESET_BIT]=1 for exactly one cycle (T+VOICES+2).
  - All other cmds bits stay 0 at all times.
- Release countdown:
  - Runs every cycle in all FSM states.
  - RELEASING with rel_cnt>0: decrement.
  - RELEASING with rel_cnt==0: becomes FREE, voice_enable drops next cycle.
  - RELEASE_TICKS=0: enable drops the cycle after commit.
  - If a countdown expiry and a COMMIT target the same slot in the same cycle, COMMIT wins (slot ends HELD).
- A retrigger of a RELEASING slot returns it to HELD and cancels the countdown.
- voice_freq of a FREE slot retains its last value.
- The scan snapshot is not reevaluated: a slot freed by the countdown during SCAN after it was examined is not considered free for that event.
- ev_key/ev_freq/ev_note_on are sampled only at the handshake; changes while ev_ready=0 are ignored.

Test Plan:
All scenarios use VOICES=4, RELEASE_TICKS=10, T = handshake cycle.
- Reset: assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, ev_ready=1; release reset, idle 5 cycles -> no output change.
- Single note-on, key 60, freq 0x0001_0000 at T:
  - ev_ready=0 during T+1..T+5;
  - at T+6, voice_enable=4'b0001, voice_freq slot0=0x0001_0000, cmds slot0 reset bit high one cycle, ev_ready=1.
- Fill and steal: note-on keys 60,61,62,63 -> enable=4'b1111. Then note-on key 64 freq 0x0002_0000 -> slot0 overwritten, stolen pulses once, slot0 reset bit pulses, enable stays 4'b1111.
- Release: note-off key 61 -> slot1 enable stays high 11 cycles after commit, then 0. Next note-on key 70 -> lands in slot1 with no stolen pulse.
- Retrigger: note-on key 62 while slot2 HELD -> slot2 freq updated, reset bit pulses on slot2 only, no other slot changes, stolen=0.
- Unknown note-off key 99 -> no output change, ev_ready returns at T+6. Assert rst_n low at T+3 of a note-on -> event dropped, all slots FREE.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphony controller assigning note events to oscillator slots
// Scans slots one per cycle, then commits: retrigger, first free, or steal oldest.
module voice_allocator #(
  parameter int VOICES             = 8,
  parameter int KEY_W              = 7,
  parameter int AGE_W              = 8,
  parameter int RELEASE_TICKS      = 4800,
  parameter int ENVELOPE_RESET_BIT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_note_on,
  input  logic [KEY_W-1:0]      ev_key,
  input  logic [31:0]           ev_freq,
  output logic [VOICES-1:0]     voice_enable,
  output logic [32*VOICES-1:0]  voice_freq,
  output logic [8*VOICES-1:0]   voice_cmds,
  output logic                  stolen
);

  localparam int IDX_W = $clog2(VOICES);
  localparam int RC_W  = (RELEASE_TICKS > 0) ? $clog2(RELEASE_TICKS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [7:0]       ENV_CMD  = 8'(1 << ENVELOPE_RESET_BIT);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} fsm_t;
  typedef enum logic [1:0] {S_FREE, S_HELD, S_RELEASING} slot_t;

  fsm_t state, state_nx;

  slot_t             slot_st  [VOICES];
  logic [KEY_W-1:0]  slot_key [VOICES];
  logic [AGE_W-1:0]  slot_age [VOICES];
  logic [RC_W-1:0]   slot_rel [VOICES];
  logic [31:0]       slot_freq[VOICES];
  logic [7:0]        slot_cmds[VOICES];

  logic              lat_on;
  logic [KEY_W-1:0]  lat_key;
  logic [31:0]       lat_freq;
  logic [IDX_W-1:0]  scan_idx;

  logic              rt_found, free_found, old_found, off_found;
  logic [IDX_W-1:0]  rt_idx, free_idx, old_idx, off_idx;
  logic [AGE_W-1:0]  old_age;

  slot_t             cur_st;
  logic [KEY_W-1:0]  cur_key;
  logic [AGE_W-1:0]  cur_age;
  logic [IDX_W-1:0]  target;
  logic              steal;
  logic              commit_on, commit_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ev_ready = 1'b0;
    case (state)
      IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) state_nx = SCAN;
      end
      SCAN:    if (scan_idx == LAST_IDX) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_st  = slot_st[scan_idx];
    cur_key = slot_key[scan_idx];
    cur_age = slot_age[scan_idx];
  end

  // Oldest-voice fallback only when nothing matched and nothing was free.
  always_comb begin
    target = old_idx;
    steal  = 1'b0;
    if (rt_found)        target = rt_idx;
    else if (free_found) target = free_idx;
    else                 steal  = 1'b1;
  end

  assign commit_on  = (state == COMMIT) && lat_on;
  assign commit_off = (state == COMMIT) && !lat_on && off_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_on     <= 1'b0;
      lat_key    <= '0;
      lat_freq   <= '0;
      scan_idx   <= '0;
      rt_found   <= 1'b0;
      free_found <= 1'b0;
      old_found  <= 1'b0;
      off_found  <= 1'b0;
      rt_idx     <= '0;
      free_idx   <= '0;
      old_idx    <= '0;
      off_idx    <= '0;
      old_age    <= '0;
    end else begin
      if (state == IDLE && ev_valid) begin
        lat_on     <= ev_note_on;
        lat_key    <= ev_key;
        lat_freq   <= ev_freq;
        scan_idx   <= '0;
        rt_found   <= 1'b0;
        free_found <= 1'b0;
        old_found  <= 1'b0;
        off_found  <= 1'b0;
      end else if (state == SCAN) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (lat_on) begin
          if (!rt_found && cur_st != S_FREE && cur_key == lat_key) begin
            rt_found <= 1'b1;
            rt_idx   <= scan_idx;
          end
          if (!free_found && cur_st == S_FREE) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (cur_st != S_FREE && (!old_found || cur_age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= cur_age;
          end
        end else if (!off_found && cur_st == S_HELD && cur_key == lat_key) begin
          off_found <= 1'b1;
          off_idx   <= scan_idx;
        end
      end
    end
  end

  // Countdown first; a commit to the same slot later in the block overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stolen <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        slot_st[i]   <= S_FREE;
        slot_key[i]  <= '0;
        slot_age[i]  <= '0;
        slot_rel[i]  <= '0;
        slot_freq[i] <= '0;
        slot_cmds[i] <= '0;
      end
    end else begin
      stolen <= commit_on && steal;
      for (int i = 0; i < VOICES; i++) begin
        slot_cmds[i] <= '0;
        if (slot_st[i] == S_RELEASING) begin
          if (slot_rel[i] != '0) slot_rel[i] <= slot_rel[i] - RC_W'(1);
          else                   slot_st[i]  <= S_FREE;
        end
        if (commit_on) begin
          if (target == IDX_W'(i)) begin
            slot_st[i]   <= S_HELD;
            slot_key[i]  <= lat_key;
            slot_freq[i] <= lat_freq;
            slot_age[i]  <= '0;
            slot_cmds[i] <= ENV_CMD;
          end else if (slot_st[i] != S_FREE && slot_age[i] != AGE_MAX) begin
            slot_age[i] <= slot_age[i] + AGE_W'(1);
          end
        end
        if (commit_off && off_idx == IDX_W'(i)) begin
          slot_st[i]  <= S_RELEASING;
          slot_rel[i] <= RC_W'(RELEASE_TICKS);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      voice_enable[i]       = (slot_st[i] != S_FREE);
      voice_freq[32*i +: 32] = slot_freq[i];
      voice_cmds[8*i +: 8]   = slot_cmds[i];
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed scoreboard bench for voice_allocator
// Four slots, ten-cycle release tail; expectations queued at each event.
module tb_voice_allocator;

  localparam int V  = 4;
  localparam int KW = 7;
  localparam int RT = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_note_on = 1'b0;
  logic [KW-1:0] ev_key = '0;
  logic [31:0]   ev_freq = '0;
  logic          ev_ready;
  logic [V-1:0]  voice_enable;
  logic [32*V-1:0] voice_freq;
  logic [8*V-1:0]  voice_cmds;
  logic          stolen;

  voice_allocator #(
    .VOICES(V), .KEY_W(KW), .AGE_W(8), .RELEASE_TICKS(RT), .ENVELOPE_RESET_BIT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_note_on(ev_note_on), .ev_key(ev_key), .ev_freq(ev_freq),
    .voice_enable(voice_enable), .voice_freq(voice_freq),
    .voice_cmds(voice_cmds), .stolen(stolen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   en;
    logic [127:0] freq;
    logic [31:0]  cmds;
    logic         stl;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mf[V];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fvec();
    return {mf[3], mf[2], mf[1], mf[0]};
  endfunction

  // cmd_slot: slot whose envelope-reset bit should pulse, -1 for none.
  task automatic send(input logic on, input logic [KW-1:0] key, input logic [31:0] freq,
                      input logic [3:0] en, input int cmd_slot, input logic stl);
    exp_t e;
    if (on && cmd_slot >= 0) mf[cmd_slot] = freq;
    e.en   = en;
    e.freq = fvec();
    e.cmds = (cmd_slot >= 0) ? (32'h1 << (8 * cmd_slot)) : 32'h0;
    e.stl  = stl;
    sb.push_back(e);
    @(negedge clk);
    chk("ready_idle", 128'(ev_ready), 128'(1'b1));
    ev_valid   = 1'b1;
    ev_note_on = on;
    ev_key     = key;
    ev_freq    = freq;
    @(posedge clk);
    #1;
    ev_valid   = 1'b0;
    ev_note_on = 1'($urandom);
    ev_key     = KW'($urandom);
    ev_freq    = $urandom;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("busy_T+%0d", k), 128'(ev_ready), 128'(1'b0));
    end
    @(negedge clk);
    e = sb.pop_front();
    chk("ready_T+6", 128'(ev_ready), 128'(1'b1));
    chk("enable", 128'(voice_enable), 128'(e.en));
    chk("freq", voice_freq, e.freq);
    chk("cmds", 128'(voice_cmds), 128'(e.cmds));
    chk("stolen", 128'(stolen), 128'(e.stl));
    @(negedge clk);
    chk("cmds_T+7", 128'(voice_cmds), 128'(32'h0));
    chk("stolen_T+7", 128'(stolen), 128'(1'b0));
  endtask

  initial begin
    for (int i = 0; i < V; i++) mf[i] = '0;

    repeat (2) @(negedge clk);
    chk("rst_enable", 128'(voice_enable), 128'(4'b0));
    chk("rst_freq", voice_freq, 128'(0));
    chk("rst_cmds", 128'(voice_cmds), 128'(0));
    chk("rst_stolen", 128'(stolen), 128'(1'b0));
    chk("rst_ready", 128'(ev_ready), 128'(1'b1));
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_enable", 128'(voice_enable), 128'(4'b0));
      chk("idle_freq", voice_freq, 128'(0));
      chk("idle_cmds", 128'(voice_cmds), 128'(0));
      chk("idle_ready", 128'(ev_ready), 128'(1'b1));
    end

    send(1'b1, 7'd60, 32'h0001_0000, 4'b0001, 0, 1'b0);
    send(1'b1, 7'd61, 32'h0001_1000, 4'b0011, 1, 1'b0);
    send(1'b1, 7'd62, 32'h0001_2000, 4'b0111, 2, 1'b0);
    send(1'b1, 7'd63, 32'h0001_3000, 4'b1111, 3, 1'b0);
    send(1'b1, 7'd64, 32'h0002_0000, 4'b1111, 0, 1'b1);

    // Release tail: enable held 11 cycles after commit, of which send() saw two.
    send(1'b0, 7'd61, 32'h0, 4'b1111, -1, 1'b0);
    for (int k = 0; k < RT - 1; k++) begin
      @(negedge clk);
      chk("tail_enable", 128'(voice_enable), 128'(4'b1111));
    end
    @(negedge clk);
    chk("tail_drop", 128'(voice_enable), 128'(4'b1101));

    send(1'b1, 7'd70, 32'h0003_0000, 4'b1111, 1, 1'b0);
    send(1'b1, 7'd62, 32'h0004_0000, 4'b1111, 2, 1'b0);
    send(1'b0, 7'd99, 32'h0, 4'b1111, -1, 1'b0);
    send(1'b1, 7'd65, 32'h0005_0000, 4'b1111, 3, 1'b1);

    // Reset during the scan of a note-on drops that event.
    @(negedge clk);
    ev_valid   = 1'b1;
    ev_note_on = 1'b1;
    ev_key     = 7'd66;
    ev_freq    = 32'h0006_0000;
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < V; i++) mf[i] = '0;
    chk("async_enable", 128'(voice_enable), 128'(4'b0));
    chk("async_freq", voice_freq, 128'(0));
    chk("async_cmds", 128'(voice_cmds), 128'(0));
    chk("async_ready", 128'(ev_ready), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("dropped_enable", 128'(voice_enable), 128'(4'b0));
    send(1'b1, 7'd67, 32'h0007_0000, 4'b0001, 0, 1'b0);

    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
